// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle controller.
//   state_t   : FSM state encoding (IDLE..WB, TRAP)
//   OP_*/FN_* : supported opcode / R-type funct values
//   PC_*/RD_*/RI_*/ALU_* : datapath select encodings
//   ctrl_t    : bundle of per-state control outputs
//   is_legal  : opcode/funct legality check used at DECODE
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] RI_ALU = 2'd0;
  localparam logic [1:0] RI_MEM = 2'd1;
  localparam logic [1:0] RI_PC4 = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_SLT = 2'd3;

  typedef struct packed {
    logic [1:0] pc_next;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       reg_we;
    logic [1:0] reg_in;
    logic       mem_we;
    logic       beq;
    logic       bne;
    logic       pc_we;
    logic       ir_we;
    logic       mem_re;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_XORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: pure combinational map (state, op_q, fn_q) -> control bundle.
//   state : current FSM state
//   op_q  : latched opcode
//   fn_q  : latched funct
//   ctl   : control outputs; anything not used in a state is 0
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic [5:0] fn_q,
  output ctrl_t      ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_re  = 1'b1;
        ctl.ir_we   = 1'b1;
        ctl.pc_we   = 1'b1;
        ctl.pc_next = PC_PLUS4;
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            if (fn_q == FN_JR) begin
              ctl.pc_we   = 1'b1;
              ctl.pc_next = PC_REG;
            end else begin
              ctl.alu_src  = 1'b0;
              ctl.alu_ctrl = (fn_q == FN_SUB) ? ALU_SUB :
                             (fn_q == FN_SLT) ? ALU_SLT : ALU_ADD;
            end
          end
          OP_LW, OP_SW, OP_ADDI: begin
            ctl.alu_src  = 1'b1;
            ctl.alu_ctrl = ALU_ADD;
          end
          OP_XORI: begin
            ctl.alu_src  = 1'b1;
            ctl.alu_ctrl = ALU_XOR;
          end
          OP_BEQ, OP_BNE: begin
            ctl.alu_ctrl = ALU_SUB;
            ctl.beq      = (op_q == OP_BEQ);
            ctl.bne      = (op_q == OP_BNE);
            ctl.pc_we    = 1'b1;
            ctl.pc_next  = PC_BRANCH;
          end
          OP_J: begin
            ctl.pc_we   = 1'b1;
            ctl.pc_next = PC_JUMP;
          end
          OP_JAL: begin
            ctl.pc_we   = 1'b1;
            ctl.pc_next = PC_JUMP;
            ctl.reg_we  = 1'b1;
            ctl.reg_dst = RD_RA;
            ctl.reg_in  = RI_PC4;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctl.mem_re = (op_q == OP_LW);
        ctl.mem_we = (op_q == OP_SW);
      end
      S_WB: begin
        ctl.reg_we  = 1'b1;
        ctl.reg_dst = (op_q == OP_R) ? RD_RD : RD_RT;
        ctl.reg_in  = (op_q == OP_LW) ? RI_MEM : RI_ALU;
      end
      S_TRAP: ctl.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-subset control FSM.
//   clk, rst_n (sync, active low); opcode/funct from IR; mem_ready handshake
//   core controls: pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in,
//                  mem_we, beq, bne
//   sequencing:    pc_we, ir_we, mem_re, illegal, mem_timeout, state, instret
// Build option: define MEM_HANDSHAKE_EN to stall FETCH/MEM on mem_ready and
// trap after more than MEM_WAIT_MAX stall cycles; otherwise memory is
// single-cycle and mem_ready is ignored.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic [1:0]  pc_next,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_ctrl,
  output logic        reg_we,
  output logic [1:0]  reg_in,
  output logic        mem_we,
  output logic        beq,
  output logic        bne,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_re,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  state_t      state_q, nxt;
  logic [5:0]  op_q, fn_q;
  logic [31:0] instret_q;
  logic        timeout_q;
  logic        stall, wait_hit, retire;
  ctrl_t       ctl;

`ifdef MEM_HANDSHAKE_EN
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  logic [WW-1:0] wait_q;

  // A stall cycle is any FETCH/MEM cycle without mem_ready; the one that
  // would push the wait past MEM_WAIT_MAX diverts to TRAP instead.
  assign stall    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wait_hit = stall && (wait_q == WW'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n)     wait_q <= '0;
    else if (stall) wait_q <= wait_q + WW'(1);
    else            wait_q <= '0;
  end
`else
  logic unused_mem;
  assign unused_mem = mem_ready ^ (MEM_WAIT_MAX == 0);
  assign stall      = 1'b0;
  assign wait_hit   = 1'b0;
`endif

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (wait_hit) nxt = S_TRAP; else if (!stall) nxt = S_DECODE;
      S_DECODE: nxt = is_legal(opcode, funct) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          OP_R:             nxt = (fn_q == FN_JR) ? S_FETCH : S_WB;
          OP_LW, OP_SW:     nxt = S_MEM;
          OP_ADDI, OP_XORI: nxt = S_WB;
          default:          nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (wait_hit)    nxt = S_TRAP;
        else if (!stall) nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    nxt = S_FETCH;
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  // An instruction retires on the cycle that hands control back to FETCH.
  assign retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                  && (nxt == S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      instret_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= nxt;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (retire)   instret_q <= instret_q + 32'd1;
      if (wait_hit) timeout_q <= 1'b1;
    end
  end

  ctrl_decode u_dec (
    .state (state_q),
    .op_q  (op_q),
    .fn_q  (fn_q),
    .ctl   (ctl)
  );

  // Write strobes only fire on the cycle memory actually completes.
  assign pc_next     = ctl.pc_next;
  assign reg_dst     = ctl.reg_dst;
  assign alu_src     = ctl.alu_src;
  assign alu_ctrl    = ctl.alu_ctrl;
  assign reg_we      = ctl.reg_we;
  assign reg_in      = ctl.reg_in;
  assign mem_we      = ctl.mem_we & ~stall;
  assign beq         = ctl.beq;
  assign bne         = ctl.bne;
  assign pc_we       = ctl.pc_we & ~stall;
  assign ir_we       = ctl.ir_we & ~stall;
  assign mem_re      = ctl.mem_re;
  assign illegal     = ctl.illegal;
  assign mem_timeout = timeout_q;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions whose expected per-cycle
// state/controls/instret are queued when driven and checked on negedge, plus
// hand-written trap, reset-abort, wrap and memory-handshake sequences.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic [1:0]  pc_next, reg_dst, alu_ctrl, reg_in;
  logic        alu_src, reg_we, mem_we, beq, bne, pc_we, ir_we, mem_re, illegal, mem_timeout;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_next(pc_next), .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .reg_we(reg_we), .reg_in(reg_in), .mem_we(mem_we), .beq(beq), .bne(bne),
    .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .illegal(illegal),
    .mem_timeout(mem_timeout), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // {pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we, beq, bne, pc_we, ir_we, mem_re, illegal}
  typedef logic [16:0] tctl_t;

  typedef struct packed {
    logic [2:0]  st;
    tctl_t       c;
    logic        to;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    logic [2:0] s4;
    tctl_t      x3, x4, x5;
  } vec_t;

  exp_t  q[$];
  exp_t  act, mon_e;
  int    checks = 0;
  int    failures = 0;
  logic [31:0] exp_instret;
  vec_t  vt[12];
  tctl_t C0, CF, CT;

  assign act = {state, pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we,
                beq, bne, pc_we, ir_we, mem_re, illegal, mem_timeout, instret};

  function automatic tctl_t tc(input int pn, input int rd, input int as_, input int ac,
                               input int rw, input int ri, input int mw, input int bq,
                               input int bn, input int pw, input int iw, input int mr,
                               input int il);
    return {pn[1:0], rd[1:0], as_[0], ac[1:0], rw[0], ri[1:0], mw[0], bq[0], bn[0],
            pw[0], iw[0], mr[0], il[0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input tctl_t c);
    q.push_back(exp_t'({st, c, 1'b0, exp_instret}));
  endtask

  // Scoreboard side: one expected record per cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      chk("cycle", 64'(act), 64'(mon_e));
    end
  end

  // Called #1 after an edge with reset already applied; returns #1 into FETCH.
  task automatic restart();
    rst_n = 1'b1;
    exp_instret = 32'd0;
    push(3'd0, C0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    opcode = v.op; funct = v.fn;
    push(3'd1, CF);
    push(3'd2, C0);
    push(3'd3, v.x3);
    if (v.len >= 4) push(v.s4, v.x4);
    if (v.len == 5) push(3'd5, v.x5);
    exp_instret = exp_instret + 32'd1;
    repeat (v.len) @(posedge clk);
    #1;
  endtask

  task automatic do_trap(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; funct = fn;
    push(3'd1, CF);
    push(3'd2, C0);
    repeat (3) push(3'd7, CT);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("trap_rst_state", 64'(state), 64'(0));
    chk("trap_rst_illegal", 64'({illegal, mem_timeout}), 64'(0));
    chk("trap_rst_instret", 64'(instret), 64'(0));
    restart();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    C0 = '0;
    CF = tc(0,0,0,0,0,0,0,0,0,1,1,1,0);
    CT = tc(0,0,0,0,0,0,0,0,0,0,0,0,1);
    //            op     fn    len s4    exec                              4th                               5th
    vt[0]  = '{6'h23, 6'h3F, 5, 3'd4, tc(0,0,1,0,0,0,0,0,0,0,0,0,0), tc(0,0,0,0,0,0,0,0,0,0,0,1,0), tc(0,0,0,0,1,1,0,0,0,0,0,0,0)}; // LW
    vt[1]  = '{6'h00, 6'h22, 4, 3'd5, tc(0,0,0,1,0,0,0,0,0,0,0,0,0), tc(0,1,0,0,1,0,0,0,0,0,0,0,0), C0}; // SUB
    vt[2]  = '{6'h05, 6'h3F, 3, 3'd0, tc(1,0,0,1,0,0,0,0,1,1,0,0,0), C0, C0}; // BNE
    vt[3]  = '{6'h04, 6'h00, 3, 3'd0, tc(1,0,0,1,0,0,0,1,0,1,0,0,0), C0, C0}; // BEQ
    vt[4]  = '{6'h00, 6'h20, 4, 3'd5, C0,                            tc(0,1,0,0,1,0,0,0,0,0,0,0,0), C0}; // ADD
    vt[5]  = '{6'h00, 6'h2A, 4, 3'd5, tc(0,0,0,3,0,0,0,0,0,0,0,0,0), tc(0,1,0,0,1,0,0,0,0,0,0,0,0), C0}; // SLT
    vt[6]  = '{6'h00, 6'h08, 3, 3'd0, tc(3,0,0,0,0,0,0,0,0,1,0,0,0), C0, C0}; // JR
    vt[7]  = '{6'h02, 6'h15, 3, 3'd0, tc(2,0,0,0,0,0,0,0,0,1,0,0,0), C0, C0}; // J
    vt[8]  = '{6'h03, 6'h00, 3, 3'd0, tc(2,2,0,0,1,2,0,0,0,1,0,0,0), C0, C0}; // JAL
    vt[9]  = '{6'h2B, 6'h22, 4, 3'd4, tc(0,0,1,0,0,0,0,0,0,0,0,0,0), tc(0,0,0,0,0,0,1,0,0,0,0,0,0), C0}; // SW
    vt[10] = '{6'h08, 6'h2A, 4, 3'd5, tc(0,0,1,0,0,0,0,0,0,0,0,0,0), tc(0,0,0,0,1,0,0,0,0,0,0,0,0), C0}; // ADDI
    vt[11] = '{6'h0E, 6'h3F, 4, 3'd5, tc(0,0,1,2,0,0,0,0,0,0,0,0,0), tc(0,0,0,0,1,0,0,0,0,0,0,0,0), C0}; // XORI

    rst_n = 1'b0; opcode = 6'h23; funct = 6'h00; exp_instret = 32'd0;
`ifdef MEM_HANDSHAKE_EN
    mem_ready = 1'b1;
`else
    mem_ready = 1'b0;  // must be ignored: every access still single-cycle
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_all_zero", 64'(act), 64'(0));
    restart();

    foreach (vt[i]) run_vec(vt[i]);

    // instret wrap on a jump
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    run_vec(vt[7]);
    run_vec(vt[2]);

    do_trap(6'h3F, 6'h20);
    do_trap(6'h00, 6'h21);

    // reset in the middle of an LW (while in MEM)
    opcode = 6'h23; funct = 6'h00;
    push(3'd1, CF);
    push(3'd2, C0);
    push(3'd3, vt[0].x3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", 64'(state), 64'(0));
    chk("abort_we", 64'({reg_we, mem_we, pc_we, ir_we, mem_re}), 64'(0));
    @(posedge clk); #1;
    chk("abort_hold", 64'(act), 64'(0));
    restart();
    run_vec(vt[4]);

`ifdef MEM_HANDSHAKE_EN
    // SW with mem_ready low for 3 MEM cycles
    opcode = 6'h2B; funct = 6'h00;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("hs_stall_state", 64'(state), 64'(4));
      chk("hs_stall_mem_we", 64'(mem_we), 64'(0));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; #1;
    chk("hs_ready_mem_we", 64'({state, mem_we}), 64'({3'd4, 1'b1}));
    @(posedge clk); #1;
    chk("hs_sw_done", 64'({state, instret}), 64'({3'd1, exp_instret + 32'd1}));
    // FETCH held off 16 cycles -> timeout trap
    mem_ready = 1'b0; #1;
    chk("hs_fetch_gate", 64'({mem_re, ir_we, pc_we}), 64'(3'b100));
    repeat (15) @(posedge clk);
    #1;
    chk("hs_pre_timeout", 64'({state, mem_timeout}), 64'({3'd1, 1'b0}));
    @(posedge clk); #1;
    chk("hs_timeout", 64'({state, mem_timeout, illegal}), 64'({3'd7, 1'b1, 1'b1}));
    rst_n = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_timeout_rst", 64'({state, mem_timeout, illegal}), 64'(0));
    restart();
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum number of stall cycles before memory timeout (used only with MEM_HANDSHAKE_EN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have inputs opcode[5:0] and funct[5:0], driven from the instruction register.
REQ-005 SHALL have input mem_ready, 1 bit: memory access complete (ignored without MEM_HANDSHAKE_EN).
REQ-006 SHALL have core-control outputs: pc_next[1:0], reg_dst[1:0], alu_src, alu_ctrl[1:0], reg_we, reg_in[1:0], mem_we, beq, bne.
REQ-007 SHALL have sequencing outputs: pc_we, ir_we, mem_re, illegal, mem_timeout (1 bit each), state[2:0] and instret[31:0].

Function
REQ-008 Encodings SHALL be: pc_next 0=PC+4, 1=branch, 2=jump, 3=register; reg_dst 0=rt, 1=rd, 2=$31; reg_in 0=ALU, 1=mem, 2=PC+4; alu_ctrl 0=add, 1=sub, 2=xor, 3=slt.
REQ-009 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
REQ-010 IDLE SHALL go to FETCH unconditionally; in IDLE every output SHALL be 0.
REQ-011 FETCH SHALL assert mem_re, ir_we, and pc_we with pc_next=0, then go to DECODE.
REQ-012 DECODE SHALL latch opcode and funct into op_q and fn_q; all write enables SHALL be 0.
REQ-013 DECODE transitions: legal opcode -> EXEC; any other opcode, or R-type with unsupported funct -> TRAP.
REQ-014 Legal opcodes: R 0x00 (funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08), LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, ADDI 0x08, XORI 0x0E.
REQ-015 EXEC actions: R -> alu_src=0 with alu_ctrl from funct, then WB; LW/SW/ADDI -> alu_src=1, add; XORI -> alu_src=1, xor; LW/SW -> MEM; ADDI/XORI -> WB.
REQ-016 EXEC branches: BEQ/BNE SHALL assert alu_ctrl=sub, beq or bne respectively, pc_we=1, pc_next=1, then go to FETCH.
REQ-017 EXEC jumps: J -> pc_we, pc_next=2; JAL -> additionally reg_we, reg_dst=2, reg_in=2; JR -> pc_we, pc_next=3; all three then go to FETCH.
REQ-018 MEM: LW asserts mem_re and goes to WB; SW asserts mem_we and goes to FETCH.
REQ-019 WB SHALL assert reg_we with: R -> reg_dst=1, reg_in=0; ADDI/XORI -> reg_dst=0, reg_in=0; LW -> reg_dst=0, reg_in=1; then go to FETCH.
REQ-020 Outputs SHALL be combinational from state, op_q and fn_q only; output latencies are J/JAL/JR/BEQ/BNE 3 cycles, R/ADDI/XORI/SW 4 cycles, LW 5 cycles.
REQ-021 instret SHALL increment by 1 on the last cycle of each instruction and wrap from 0xFFFFFFFF to 0.
REQ-022 TRAP SHALL hold with illegal=1, all write enables 0, and instret frozen, until reset.
REQ-023 Signals unused in a state SHALL be driven to 0.

Reset
REQ-024 With rst_n sampled low at a clock edge: state=IDLE, op_q=fn_q=0, instret=0, wait counter=0, illegal=0, mem_timeout=0.
REQ-025 Reset asserted in any state, mid-instruction included, SHALL abort that instruction with no further write enables asserted.

Configuration
REQ-026 Macro MEM_HANDSHAKE_EN defined: FETCH and MEM SHALL hold, with write enables gated off, until mem_ready=1; ir_we, pc_we and mem_we SHALL assert only in the mem_ready cycle.
REQ-027 With MEM_HANDSHAKE_EN, a wait exceeding MEM_WAIT_MAX cycles SHALL go to TRAP with mem_timeout=1.
REQ-028 Macro MEM_HANDSHAKE_EN undefined: memory SHALL be single-cycle, mem_ready SHALL be ignored, and mem_timeout SHALL be tied to 0.

Structure
REQ-029 Package ctrl_pkg SHALL hold the state encoding, opcode/funct constants, and the pc_next/reg_dst/reg_in/alu_ctrl encodings.
REQ-030 The design SHALL contain one sub-module, ctrl_decode: a combinational map from (state, op_q, fn_q) to outputs, reused by the verification model.

Verification
REQ-031 Release reset, opcode=0x23 -> states 0,1,2,3,4,5,1; WB shows reg_we=1, reg_in=1, reg_dst=0; instret=1 after WB.
REQ-032 opcode=0x00, funct=0x22 -> EXEC shows alu_ctrl=1, alu_src=0; WB shows reg_dst=1; 4 cycles from FETCH to FETCH.
REQ-033 opcode=0x05 -> EXEC shows bne=1, beq=0, pc_next=1, pc_we=1; back in FETCH 3 cycles after the prior FETCH.
REQ-034 opcode=0x3F -> TRAP, illegal=1, instret unchanged; rst_n=0 for one cycle -> state=IDLE and illegal=0.
REQ-035 With MEM_HANDSHAKE_EN: SW with mem_ready low 3 cycles -> mem_we=0 for 3 cycles, then 1 for one cycle; mem_ready held low 16 cycles -> mem_timeout=1.
REQ-036 Preload instret=0xFFFFFFFF (via force), run J -> instret=0.
